thermal_tx_scheduler: RTL and testbench
=======================================

// Module: thermal_tx_scheduler
// PURPOSE
//  Transmit-side sequencer for the thermal covert channel. Accepts one data word per frame on a
//  valid/ready handshake and frames it as preamble + data + cooldown gap. Each frame bit occupies
//  one fixed-length time slot, and the frame is sent as on/off keying of the heater enable.
//  heater_en gates the ring-oscillator heater bank; the receiver recovers bits from slot timing.
// PARAMETERS
//  SLOT_CYCLES     50_000_000  clk cycles per bit slot (0.5 s at 100 MHz); legal range >= 2
//  DATA_W          8           payload bits per frame, sent MSB first
//  PREAMBLE_BITS   4           preamble length in slots
//  PREAMBLE        4'b1011     preamble pattern (PREAMBLE_BITS wide), sent MSB first
//  GAP_SLOTS       2           heater-off cooldown slots after the data; legal range >= 1
// PORTS
//  clk          in   1                  system clock
//  reset        in   1                  synchronous, active-high reset
//  tx_data      in   DATA_W             payload word; sampled on handshake
//  tx_valid     in   1                  payload available
//  tx_ready     out  1                  high only in IDLE; handshake = tx_valid & tx_ready at posedge
//  abort        in   1                  synchronous frame cancel
//  heater_en    out  1                  registered heater bank enable
//  busy         out  1                  high in every state except IDLE
//  frame_done   out  1                  one-cycle pulse when a frame completes normally
//  state_o      out  2                  debug state code: 0 IDLE, 1 PRE, 2 DATA, 3 GAP
// BEHAVIOUR
//  - One clock, clk. reset is synchronous and active-high and overrides everything, including abort.
//  - Reset values: state = IDLE, tx_ready = 1, heater_en = 0, busy = 0, frame_done = 0,
//    slot_cnt = 0, bit_cnt = 0, shift register = 0.
//  - slot_cnt is $clog2(SLOT_CYCLES) bits wide and counts 0..SLOT_CYCLES-1. The slot ends when
//    slot_cnt == SLOT_CYCLES-1; slot_cnt then wraps to 0.
//  - bit_cnt counts slots within the current state.
//  - IDLE: on handshake edge E0, latch tx_data into the shift register. Then go to PRE with
//    slot_cnt = 0 and bit_cnt = 0. tx_valid without tx_ready has no effect.
//  - PRE: heater_en = PREAMBLE[PREAMBLE_BITS-1-bit_cnt]. After PREAMBLE_BITS slots, go to DATA.
//  - DATA: heater_en = shift register MSB. The register shifts left by 1 at each slot end.
//    After DATA_W slots, go to GAP.
//  - GAP: heater_en = 0. After GAP_SLOTS slots, go to IDLE.
//  - Cycle timing: heater_en for frame slot k (k = 0..N-1, N = PREAMBLE_BITS+DATA_W+GAP_SLOTS)
//    holds on cycles E0+1+k*SLOT_CYCLES through E0+(k+1)*SLOT_CYCLES. Every slot is exactly
//    SLOT_CYCLES cycles long; there are no bubbles between slots.
//  - Completion: on cycle E0+N*SLOT_CYCLES+1, state = IDLE, tx_ready = 1, busy = 0, and
//    frame_done = 1 for exactly that one cycle.
//  - Back-to-back frames: a handshake is accepted on the frame_done cycle. The next preamble
//    starts on the following cycle, so the minimum inter-frame heater-off time is
//    GAP_SLOTS*SLOT_CYCLES + 1 cycle.
//  - abort: sampled every cycle. In a non-IDLE state it forces IDLE on the next edge with
//    heater_en = 0 and no frame_done. The counters clear and the shift register is kept but ignored.
//  - abort in IDLE: abort has priority over a simultaneous handshake; the word is not accepted.
//  - Mid-frame reset: reset mid-frame behaves like abort and additionally clears the shift register.
//  - heater_en, busy, frame_done and state_o are all registered. There are no combinational
//    paths from inputs to outputs except tx_ready, which decodes state only.
//  - tx_data changes outside the handshake edge have no effect on the frame in flight.
// TESTING  (bench uses SLOT_CYCLES=4, DATA_W=8, PREAMBLE=4'b1011, GAP_SLOTS=2 -> N=14, frame 56 cyc)
//  1 Reset: hold reset 3 cycles with tx_valid=1 -> tx_ready=1, heater_en=0, busy=0, no accept.
//  2 Single frame tx_data=8'hA5 -> heater_en per 4-cycle slot = 1,0,1,1,1,0,1,0,0,1,0,1,0,0.
//    Required: frame_done on cycle E0+57, busy high on cycles E0+1..E0+56.
//  3 Back-to-back: 8'hFF, then 8'h00 offered on the frame_done cycle -> second accepted there.
//    Required: second preamble starts 1 cycle later; the heater-off gap is 9 cycles.
//  4 abort on DATA slot 2, mid-slot -> next cycle IDLE, heater_en=0, no frame_done.
//    A new word 8'h3C then sends a correct full frame.
//  5 abort and tx_valid together in IDLE -> no accept, tx_ready stays 1, heater_en stays 0.
//  6 reset asserted in GAP -> next cycle all outputs at reset values, no frame_done pulse.

Source files
------------

// File: rtl/thermal_tx_scheduler.sv
// Thermal covert-channel transmit sequencer: frames one word as preamble + data + gap
// and sends each frame bit as one SLOT_CYCLES-long on/off slot of the heater bank.
module thermal_tx_scheduler #(
  parameter int                       SLOT_CYCLES   = 50_000_000,
  parameter int                       DATA_W        = 8,
  parameter int                       PREAMBLE_BITS = 4,
  parameter logic [PREAMBLE_BITS-1:0] PREAMBLE      = 4'b1011,
  parameter int                       GAP_SLOTS     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              abort,
  output logic              heater_en,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        state_o
);

  // state | meaning
  // IDLE  | waiting for a word, heater off, tx_ready high
  // PRE   | sending preamble slots, MSB first
  // DATA  | sending payload slots from the shift register MSB
  // GAP   | heater-off cooldown slots before returning to IDLE
  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, DATA = 2'd2, GAP = 2'd3} state_t;

  localparam int SW   = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam int MAX1 = (DATA_W > PREAMBLE_BITS) ? DATA_W : PREAMBLE_BITS;
  localparam int MAXB = (MAX1 > GAP_SLOTS) ? MAX1 : GAP_SLOTS;
  localparam int BW   = $clog2(MAXB + 1);

  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
  localparam logic [BW-1:0] PRE_LAST  = BW'(PREAMBLE_BITS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] GAP_LAST  = BW'(GAP_SLOTS - 1);

  state_t                   state;
  logic [SW-1:0]            slot_cnt;
  logic [BW-1:0]            bit_cnt;
  logic [DATA_W-1:0]        shift_reg;
  logic [DATA_W-1:0]        shift_next;
  logic [PREAMBLE_BITS-1:0] pre_next;
  logic                     slot_end;

  // Heater value for the following slot is registered at the slot boundary,
  // so it is looked up one bit ahead here.
  always_comb begin
    shift_next = shift_reg << 1;
    pre_next   = PREAMBLE << (bit_cnt + BW'(1));
    slot_end   = (slot_cnt == SLOT_LAST);
  end

  assign tx_ready = (state == IDLE);
  assign state_o  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      heater_en  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      slot_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (abort) begin
        // Shift register is left as is; it is reloaded on the next handshake.
        state     <= IDLE;
        heater_en <= 1'b0;
        busy      <= 1'b0;
        slot_cnt  <= '0;
        bit_cnt   <= '0;
      end else if (state == IDLE) begin
        if (tx_valid) begin
          shift_reg <= tx_data;
          state     <= PRE;
          heater_en <= PREAMBLE[PREAMBLE_BITS-1];
          busy      <= 1'b1;
          slot_cnt  <= '0;
          bit_cnt   <= '0;
        end
      end else if (!slot_end) begin
        slot_cnt <= slot_cnt + SW'(1);
      end else begin
        slot_cnt <= '0;
        case (state)
          PRE: begin
            if (bit_cnt == PRE_LAST) begin
              state     <= DATA;
              bit_cnt   <= '0;
              heater_en <= shift_reg[DATA_W-1];
            end else begin
              bit_cnt   <= bit_cnt + BW'(1);
              heater_en <= pre_next[PREAMBLE_BITS-1];
            end
          end
          DATA: begin
            shift_reg <= shift_next;
            if (bit_cnt == DATA_LAST) begin
              state     <= GAP;
              bit_cnt   <= '0;
              heater_en <= 1'b0;
            end else begin
              bit_cnt   <= bit_cnt + BW'(1);
              heater_en <= shift_next[DATA_W-1];
            end
          end
          GAP: begin
            heater_en <= 1'b0;
            if (bit_cnt == GAP_LAST) begin
              state      <= IDLE;
              bit_cnt    <= '0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
          default: begin
            state     <= IDLE;
            heater_en <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_thermal_tx_scheduler.sv
// Bench for thermal_tx_scheduler: directed frames plus random words, checked cycle by cycle
// against a frame-bit-vector model of the slot schedule.
module tb_thermal_tx_scheduler;

  localparam int S     = 4;
  localparam int DW    = 8;
  localparam int PB    = 4;
  localparam int GS    = 2;
  localparam int N     = PB + DW + GS;
  localparam int FRAME = N * S;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          abort;
  logic          heater_en;
  logic          busy;
  logic          frame_done;
  logic [1:0]    state_o;

  int total = 0;
  int bad = 0;
  int off_run = 0;
  int start_gap = 0;

  thermal_tx_scheduler #(
    .SLOT_CYCLES(S), .DATA_W(DW), .PREAMBLE_BITS(PB), .PREAMBLE(4'b1011), .GAP_SLOTS(GS)
  ) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .abort(abort), .heater_en(heater_en), .busy(busy), .frame_done(frame_done),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"},  8'(tx_ready),   8'd1);
    chk({tag, "_heater"}, 8'(heater_en),  8'd0);
    chk({tag, "_busy"},   8'(busy),       8'd0);
    chk({tag, "_state"},  8'(state_o),    8'd0);
    chk({tag, "_done"},   8'(frame_done), 8'd0);
  endtask

  // cut_mode: 0 full frame, 1 abort at cycle cut_t, 2 reset at cycle cut_t
  task automatic send_frame(input logic [DW-1:0] w, input int cut_mode, input int cut_t);
    logic [N-1:0] seq;
    logic [7:0]   est;
    int           k;
    seq = {4'b1011, w, 2'b00};
    chk("accept_ready", 8'(tx_ready), 8'd1);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int t = 1; t <= FRAME; t++) begin
      k   = (t - 1) / S;
      est = (k < PB) ? 8'd1 : (k < PB + DW) ? 8'd2 : 8'd3;
      chk("heater", 8'(heater_en), 8'(seq[N-1-k]));
      chk("busy", 8'(busy), 8'd1);
      chk("state", 8'(state_o), est);
      chk("ready_busy", 8'(tx_ready), 8'd0);
      chk("done_early", 8'(frame_done), 8'd0);
      if (heater_en === 1'b1) begin
        if (t == 1) start_gap = off_run;
        off_run = 0;
      end else begin
        off_run++;
      end
      tx_data = DW'($urandom);
      if (cut_mode != 0 && t == cut_t) begin
        if (cut_mode == 1) abort = 1'b1;
        else reset = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        reset = 1'b0;
        chk_idle("cut");
        repeat (3) begin
          @(negedge clk);
          chk_idle("after_cut");
        end
        off_run = 0;
        return;
      end
      @(negedge clk);
    end
    chk("done_pulse", 8'(frame_done), 8'd1);
    chk("done_busy", 8'(busy), 8'd0);
    chk("done_ready", 8'(tx_ready), 8'd1);
    chk("done_state", 8'(state_o), 8'd0);
    chk("done_heater", 8'(heater_en), 8'd0);
    off_run++;
  endtask

  initial begin
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    abort    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_idle("reset");
    end
    reset    = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    send_frame(8'hA5, 0, 0);
    @(negedge clk);
    chk_idle("idle_after_a5");
    chk("done_one_cycle", 8'(frame_done), 8'd0);

    // Back-to-back: second word offered on the frame_done cycle.
    send_frame(8'hFF, 0, 0);
    send_frame(8'h00, 0, 0);
    chk("b2b_gap", 8'(start_gap), 8'd9);
    @(negedge clk);

    // Abort mid-slot in DATA slot 2 (cycles 25..28 of the frame).
    send_frame(8'hC3, 1, 26);
    send_frame(8'h3C, 0, 0);
    @(negedge clk);

    // Abort beats a simultaneous handshake in IDLE.
    abort    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    @(negedge clk);
    abort    = 1'b0;
    tx_valid = 1'b0;
    chk_idle("abort_idle");
    @(negedge clk);
    chk_idle("abort_idle2");

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_frame(DW'($urandom), 0, 0);
    end

    // Reset during GAP (frame cycle 52 lies in slot 12).
    send_frame(8'h81, 2, 52);
    send_frame(8'h5A, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
